// File: rtl/dispatch_scheduler.sv
// In-order dispatch stage: a small FIFO of decoded instructions whose head is routed to the
// ALU, LSU or FLOW unit, with branch serialisation, jump flush, illegal-op drop and stall count.
package dispatch_pkg;
    typedef enum logic [1:0] {
        UNIT_ALU_INT,
        UNIT_LOAD_STORE,
        UNIT_FLOW,
        UNIT_NOT_IMPLEMENTED
    } unit_e;

    typedef struct packed {
        logic [31:0] pc;
        unit_e       unit;
        logic [7:0]  opcode;
        logic [4:0]  rd;
        logic [15:0] imm;
    } INSTRUCTION_DECODED;
endpackage

module dispatch_scheduler
    import dispatch_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               jump,
    input  logic               flow_resolved,
    input  INSTRUCTION_DECODED instruction_i,
    input  logic               valid_i,
    output logic               ready_i,
    output INSTRUCTION_DECODED instruction_o,
    output logic               alu_valid_o,
    input  logic               alu_ready_i,
    output logic               lsu_valid_o,
    input  logic               lsu_ready_i,
    output logic               flow_valid_o,
    input  logic               flow_ready_i,
    output logic               illegal_o,
    output logic [31:0]        illegal_pc_o,
    output logic [STALL_W-1:0] stall_cnt_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    typedef enum logic {RUN, WAIT_FLOW} state_e;

    state_e             state, state_next;
    INSTRUCTION_DECODED mem [DEPTH];
    logic [PW-1:0]      rd_ptr, wr_ptr;
    logic [PW:0]        count;
    logic               push, pop, head_v, illegal_pop, flow_fire;

    // The head is offered only from registered FIFO state, so a fresh push is seen one cycle later.
    always_comb begin
        ready_i       = (count != FULL_COUNT);
        push          = valid_i && ready_i && !jump;
        instruction_o = mem[rd_ptr];
        head_v        = (count != '0) && (state == RUN) && !jump;
        alu_valid_o   = head_v && (instruction_o.unit == UNIT_ALU_INT);
        lsu_valid_o   = head_v && (instruction_o.unit == UNIT_LOAD_STORE);
        flow_valid_o  = head_v && (instruction_o.unit == UNIT_FLOW);
        illegal_pop   = head_v && (instruction_o.unit == UNIT_NOT_IMPLEMENTED);
        flow_fire     = flow_valid_o && flow_ready_i;
        pop           = (alu_valid_o && alu_ready_i) || (lsu_valid_o && lsu_ready_i)
                        || flow_fire || illegal_pop;
    end

    always_comb begin
        state_next = state;
        if (jump) begin
            state_next = RUN;
        end else begin
            case (state)
                RUN:       if (flow_fire) state_next = WAIT_FLOW;
                WAIT_FLOW: if (flow_resolved) state_next = RUN;
                default:   state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (jump) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are ignored whenever count is zero.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= instruction_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_o    <= 1'b0;
            illegal_pc_o <= '0;
            stall_cnt_o  <= '0;
        end else begin
            illegal_o <= illegal_pop;
            if (illegal_pop) illegal_pc_o <= instruction_o.pc;
            if (!jump && (count != '0) && !pop && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end
endmodule

// File: tb/tb_dispatch_scheduler.sv
// Randomised plus directed bench for dispatch_scheduler: a queue-based reference model predicts
// dispatch events into a scoreboard that a separate monitor drains from the DUT outputs.
module tb_dispatch_scheduler;
    import dispatch_pkg::*;

    localparam int DEPTH     = 4;
    localparam int STALL_W   = 5;
    localparam int STALL_MAX = (1 << STALL_W) - 1;

    logic               clk, reset_n, jump, flow_resolved, valid_i, ready_i;
    INSTRUCTION_DECODED instruction_i, instruction_o;
    logic               alu_valid_o, alu_ready_i, lsu_valid_o, lsu_ready_i;
    logic               flow_valid_o, flow_ready_i, illegal_o;
    logic [31:0]        illegal_pc_o;
    logic [STALL_W-1:0] stall_cnt_o;

    dispatch_scheduler #(.DEPTH(DEPTH), .STALL_W(STALL_W)) dut (
        .clk(clk), .reset_n(reset_n), .jump(jump), .flow_resolved(flow_resolved),
        .instruction_i(instruction_i), .valid_i(valid_i), .ready_i(ready_i),
        .instruction_o(instruction_o),
        .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i),
        .lsu_valid_o(lsu_valid_o), .lsu_ready_i(lsu_ready_i),
        .flow_valid_o(flow_valid_o), .flow_ready_i(flow_ready_i),
        .illegal_o(illegal_o), .illegal_pc_o(illegal_pc_o), .stall_cnt_o(stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit                 is_illegal;
        INSTRUCTION_DECODED instr;
    } exp_t;

    exp_t               sb[$];
    INSTRUCTION_DECODED mq[$];
    bit                 m_wait;
    int                 m_stall;
    int                 n_checks = 0;
    int                 n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic INSTRUCTION_DECODED mk(input unit_e u, input logic [31:0] pc);
        INSTRUCTION_DECODED x;
        x.pc     = pc;
        x.unit   = u;
        x.opcode = 8'($urandom);
        x.rd     = 5'($urandom);
        x.imm    = 16'($urandom);
        return x;
    endfunction

    // Reference model: one step per clock edge, evaluated with that edge's inputs.
    task automatic model_step();
        logic [2:0] exp_valid;
        bit         head_v, pop, nxt_wait;
        exp_t       e;
        check("ready_i", ready_i, mq.size() != DEPTH);
        check("stall_cnt", stall_cnt_o, m_stall);
        head_v    = (mq.size() != 0) && !m_wait && !jump;
        exp_valid = 3'b000;
        pop       = 1'b0;
        nxt_wait  = m_wait;
        if (head_v) begin
            case (mq[0].unit)
                UNIT_ALU_INT:    begin exp_valid[2] = 1'b1; pop = alu_ready_i; end
                UNIT_LOAD_STORE: begin exp_valid[1] = 1'b1; pop = lsu_ready_i; end
                UNIT_FLOW: begin
                    exp_valid[0] = 1'b1;
                    pop          = flow_ready_i;
                    if (flow_ready_i) nxt_wait = 1'b1;
                end
                default: pop = 1'b1;
            endcase
        end
        check("unit_valids", {alu_valid_o, lsu_valid_o, flow_valid_o}, exp_valid);
        if (pop) begin
            e.is_illegal = (mq[0].unit == UNIT_NOT_IMPLEMENTED);
            e.instr      = mq[0];
            sb.push_back(e);
        end
        if (jump)                         nxt_wait = 1'b0;
        else if (m_wait && flow_resolved) nxt_wait = 1'b0;
        if (!jump && mq.size() != 0 && !pop && m_stall < STALL_MAX) m_stall++;
        if (jump) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (valid_i && mq.size() + (pop ? 1 : 0) != DEPTH) mq.push_back(instruction_i);
        end
        m_wait = nxt_wait;
    endtask

    task automatic observe_dispatch(input unit_e u);
        exp_t e;
        check("sb_has_dispatch", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("disp_is_legal", e.is_illegal, 1'b0);
            check("disp_unit", u, e.instr.unit);
            check("disp_instr", instruction_o, e.instr);
        end
    endtask

    // Monitor: consumes scoreboard entries strictly from what the DUT presents.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (reset_n) begin
                if (illegal_o) begin
                    check("sb_has_illegal", sb.size() != 0, 1'b1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("illegal_kind", e.is_illegal, 1'b1);
                        check("illegal_pc", illegal_pc_o, e.instr.pc);
                    end
                end
                if (alu_valid_o && alu_ready_i)   observe_dispatch(UNIT_ALU_INT);
                if (lsu_valid_o && lsu_ready_i)   observe_dispatch(UNIT_LOAD_STORE);
                if (flow_valid_o && flow_ready_i) observe_dispatch(UNIT_FLOW);
            end
        end
    end

    task automatic applyStimulus(input bit v, input INSTRUCTION_DECODED ins, input bit j,
                                 input bit fr, input bit ar, input bit lr, input bit flr);
        @(posedge clk);
        #1;
        valid_i       = v;
        instruction_i = ins;
        jump          = j;
        flow_resolved = fr;
        alu_ready_i   = ar;
        lsu_ready_i   = lr;
        flow_ready_i  = flr;
        @(negedge clk);
        model_step();
    endtask

    task automatic idle(input int n, input bit ar, input bit fr);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, fr, ar, 1'b1, 1'b1);
    endtask

    task automatic set_idle_inputs();
        valid_i       = 1'b0;
        instruction_i = '0;
        jump          = 1'b0;
        flow_resolved = 1'b0;
        alu_ready_i   = 1'b1;
        lsu_ready_i   = 1'b1;
        flow_ready_i  = 1'b1;
    endtask

    task automatic checkOutput(input string tag);
        check({tag, "_alu_valid"}, alu_valid_o, 1'b0);
        check({tag, "_lsu_valid"}, lsu_valid_o, 1'b0);
        check({tag, "_flow_valid"}, flow_valid_o, 1'b0);
        check({tag, "_illegal"}, illegal_o, 1'b0);
        check({tag, "_illegal_pc"}, illegal_pc_o, 32'h0);
        check({tag, "_stall"}, stall_cnt_o, 0);
        check({tag, "_ready"}, ready_i, 1'b1);
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        set_idle_inputs();
        #1;
        checkOutput("async_rst");
        mq.delete();
        sb.delete();
        m_wait  = 1'b0;
        m_stall = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        unit_e u;
        m_wait  = 1'b0;
        m_stall = 0;
        reset_n = 1'b0;
        set_idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        reset_n = 1'b1;

        $display("[TB] back-to-back ALU, LSU, ALU");
        applyStimulus(1, mk(UNIT_ALU_INT, 32'h10), 0, 0, 1, 1, 1);
        applyStimulus(1, mk(UNIT_LOAD_STORE, 32'h14), 0, 0, 1, 1, 1);
        applyStimulus(1, mk(UNIT_ALU_INT, 32'h18), 0, 0, 1, 1, 1);
        idle(3, 1, 0);

        $display("[TB] full FIFO with blocked ALU");
        for (int i = 0; i < 4; i++) applyStimulus(1, mk(UNIT_ALU_INT, 32'h20 + 4*i), 0, 0, 0, 1, 1);
        applyStimulus(1, mk(UNIT_ALU_INT, 32'h30), 0, 0, 0, 1, 1);
        idle(6, 1, 0);

        $display("[TB] FLOW serialisation");
        applyStimulus(1, mk(UNIT_FLOW, 32'h40), 0, 0, 1, 1, 1);
        applyStimulus(1, mk(UNIT_ALU_INT, 32'h44), 0, 0, 1, 1, 1);
        idle(3, 1, 0);
        idle(1, 1, 1);
        idle(2, 1, 0);

        $display("[TB] jump flush with concurrent push");
        for (int i = 0; i < 3; i++) applyStimulus(1, mk(UNIT_ALU_INT, 32'h50 + 4*i), 0, 0, 0, 1, 1);
        applyStimulus(1, mk(UNIT_ALU_INT, 32'h60), 1, 0, 0, 1, 1);
        idle(3, 1, 0);

        $display("[TB] FENCE dropped as illegal");
        applyStimulus(1, mk(UNIT_NOT_IMPLEMENTED, 32'h100), 0, 0, 1, 1, 1);
        applyStimulus(1, mk(UNIT_ALU_INT, 32'h104), 0, 0, 1, 1, 1);
        idle(3, 1, 0);

        $display("[TB] async reset while waiting on FLOW");
        applyStimulus(1, mk(UNIT_FLOW, 32'h200), 0, 0, 1, 1, 1);
        applyStimulus(1, mk(UNIT_ALU_INT, 32'h204), 0, 0, 1, 1, 1);
        applyStimulus(1, mk(UNIT_ALU_INT, 32'h208), 0, 0, 1, 1, 1);
        idle(2, 1, 0);
        async_reset();

        $display("[TB] randomised traffic");
        for (int i = 0; i < 3000; i++) begin
            u = ($urandom_range(0, 7) == 0) ? UNIT_NOT_IMPLEMENTED : unit_e'($urandom_range(0, 2));
            applyStimulus(($urandom_range(0, 3) != 0), mk(u, {$urandom_range(0, 65535), 2'b00}),
                          ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) != 0));
        end

        idle(10, 1, 1);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
